// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the out-of-order Wishbone arbiter.
// Tags on the slave side carry {master index, master tag}.
package wb_arb_pkg;

  typedef enum logic {
    ARB_EMPTY,
    ARB_FULL
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] tag_pack(
    input logic [31:0] idx,
    input logic [31:0] tga,
    input int          tw
  );
    return (idx << tw) | tga;
  endfunction

  function automatic logic [31:0] tag_idx(
    input logic [31:0] tgd,
    input int          tw
  );
    return tgd >> tw;
  endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Round-robin picker: first requester at or after the pointer wins.
// Purely combinational; the pointer lives in the parent.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter  int NUM_M = 2,
  localparam int IDW   = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [NUM_M-1:0] o_gnt,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  int w_j;

  // scan requesters starting at the pointer, wrapping around
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < NUM_M; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_M;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IDW'(w_j);
      end
    end
  end

endmodule

// File: rtl/wb_ooo_arbiter.sv
// Pipelined Wishbone arbiter with out-of-order response routing.
// One request register toward the slave, per-master outstanding caps.
module wb_ooo_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int NUM_M   = 2,
  parameter  int AW      = 32,
  parameter  int DW      = 64,
  parameter  int TW      = 8,
  parameter  int MAX_OUT = 4,
  localparam int IDW     = idx_w(NUM_M)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_M-1:0]       m_cyc,
  input  logic [NUM_M-1:0]       m_stb,
  input  logic [NUM_M-1:0]       m_we,
  input  logic [NUM_M*AW-1:0]    m_adr,
  input  logic [NUM_M*DW-1:0]    m_dat_w,
  input  logic [NUM_M*DW/8-1:0]  m_sel,
  input  logic [NUM_M*TW-1:0]    m_tga,
  output logic [NUM_M-1:0]       m_stall,
  output logic [NUM_M-1:0]       m_ack,
  output logic [NUM_M-1:0]       m_err,
  output logic [NUM_M-1:0]       m_rty,
  output logic [DW-1:0]          m_dat_r,
  output logic [TW-1:0]          m_tgd,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [AW-1:0]          s_adr,
  output logic [DW-1:0]          s_dat_w,
  output logic [DW/8-1:0]        s_sel,
  output logic [TW+IDW-1:0]      s_tga,
  input  logic                   s_stall,
  input  logic                   s_ack,
  input  logic                   s_err,
  input  logic                   s_rty,
  input  logic [DW-1:0]          s_dat_r,
  input  logic [TW+IDW-1:0]      s_tgd,
  output logic                   unexp_rsp
);

  typedef struct packed {
    logic [IDW-1:0]  idx;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] sel;
    logic [TW-1:0]   tga;
  } req_t;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  req_t             r_req;
  req_t             w_req_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [2:0]       r_outst [NUM_M];
  logic [NUM_M-1:0] r_ack;
  logic [NUM_M-1:0] r_err;
  logic [NUM_M-1:0] r_rty;
  logic [DW-1:0]    r_dat;
  logic [TW-1:0]    r_tgd;
  logic             r_unexp;

  logic [NUM_M-1:0] w_elig;
  logic [NUM_M-1:0] w_gnt;
  logic [IDW-1:0]   w_gidx;
  logic             w_any;
  logic             w_cap;
  logic             w_acc;
  logic             w_rsp;
  logic             w_rng;
  logic             w_ok;
  logic [IDW-1:0]   w_ridx;
  logic [NUM_M-1:0] w_roh;
  logic             w_busy;

  // eligible masters: requesting and below their outstanding cap
  always_comb begin
    w_elig = '0;
    w_busy = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      w_elig[i] = m_cyc[i] & m_stb[i] & (r_outst[i] < 3'(MAX_OUT));
      w_busy    = w_busy | (r_outst[i] != 3'd0);
    end
  end

  wb_rr_picker #(
    .NUM_M (NUM_M)
  ) u_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  assign w_acc = (r_state == ARB_FULL) & ~s_stall;
  assign w_cap = w_any & ((r_state == ARB_EMPTY) | ~s_stall);

  // granted master's fields for the request register
  always_comb begin
    w_req_nxt.idx = w_gidx;
    w_req_nxt.we  = m_we[w_gidx];
    w_req_nxt.adr = m_adr[w_gidx*AW +: AW];
    w_req_nxt.dat = m_dat_w[w_gidx*DW +: DW];
    w_req_nxt.sel = m_sel[w_gidx*(DW/8) +: DW/8];
    w_req_nxt.tga = m_tga[w_gidx*TW +: TW];
    w_ptr_nxt     = (int'(w_gidx) + 1 >= NUM_M) ? '0 : w_gidx + IDW'(1);
  end

  // next state of the single-entry request buffer
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_EMPTY: if (w_cap) w_state_nxt = ARB_FULL;
      ARB_FULL:  if (w_acc && !w_cap) w_state_nxt = ARB_EMPTY;
      default:   w_state_nxt = ARB_EMPTY;
    endcase
  end

  // decode the response index and check it against live counters
  always_comb begin
    w_rsp  = s_ack | s_err | s_rty;
    w_ridx = IDW'(tag_idx(32'(s_tgd), TW));
    w_rng  = tag_idx(32'(s_tgd), TW) < 32'(NUM_M);
    w_ok   = 1'b0;
    if (w_rsp && w_rng)
      w_ok = r_outst[w_ridx] != 3'd0;
    w_roh = '0;
    for (int i = 0; i < NUM_M; i++)
      w_roh[i] = w_ridx == IDW'(i);
  end

  // request buffer, fsm state and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_EMPTY;
      r_req   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_req <= w_req_nxt;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // per-master outstanding counters: +1 on accept, -1 on response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_M; i++) r_outst[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if ((w_acc && r_req.idx == IDW'(i)) && !(w_ok && w_roh[i]))
          r_outst[i] <= r_outst[i] + 3'd1;
        else if (!(w_acc && r_req.idx == IDW'(i)) && (w_ok && w_roh[i]))
          r_outst[i] <= r_outst[i] - 3'd1;
      end
    end
  end

  // registered response routing plus sticky unexpected-response flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= '0;
      r_err   <= '0;
      r_rty   <= '0;
      r_dat   <= '0;
      r_tgd   <= '0;
      r_unexp <= 1'b0;
    end else begin
      r_ack <= (w_ok && s_ack) ? w_roh : '0;
      r_err <= (w_ok && s_err) ? w_roh : '0;
      r_rty <= (w_ok && s_rty) ? w_roh : '0;
      if (w_ok) begin
        r_dat <= s_dat_r;
        r_tgd <= s_tgd[TW-1:0];
      end
      if (w_rsp && !w_ok) r_unexp <= 1'b1;
    end
  end

  assign m_stall   = rst_n ? ~(w_cap ? w_gnt : '0) : m_stb;
  assign m_ack     = r_ack;
  assign m_err     = r_err;
  assign m_rty     = r_rty;
  assign m_dat_r   = r_dat;
  assign m_tgd     = r_tgd;
  assign s_stb     = r_state == ARB_FULL;
  assign s_cyc     = s_stb | w_busy;
  assign s_we      = r_req.we;
  assign s_adr     = r_req.adr;
  assign s_dat_w   = r_req.dat;
  assign s_sel     = r_req.sel;
  assign s_tga     = (TW+IDW)'(tag_pack(32'(r_req.idx), 32'(r_req.tga), TW));
  assign unexp_rsp = r_unexp;

endmodule

// File: tb/tb_wb_ooo_arbiter.sv
// Self-checking bench for wb_ooo_arbiter (NUM_M=2, MAX_OUT=4).
// Scoreboards hold expected slave requests and master responses.
module tb_wb_ooo_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   m_cyc, m_stb, m_we;
  logic [63:0]  m_adr;
  logic [127:0] m_dat_w;
  logic [15:0]  m_sel;
  logic [15:0]  m_tga;
  logic [1:0]   m_stall, m_ack, m_err, m_rty;
  logic [63:0]  m_dat_r;
  logic [7:0]   m_tgd;
  logic         s_cyc, s_stb, s_we;
  logic [31:0]  s_adr;
  logic [63:0]  s_dat_w;
  logic [7:0]   s_sel;
  logic [8:0]   s_tga;
  logic         s_stall, s_ack, s_err, s_rty;
  logic [63:0]  s_dat_r;
  logic [8:0]   s_tgd;
  logic         unexp_rsp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [7:0]  tga;
    logic [31:0] adr;
  } req_e;

  typedef struct {
    logic [1:0]  ack, err, rty;
    logic [7:0]  tgd;
    logic [63:0] dat;
    bit          chk;
  } rsp_e;

  req_e req_q[$];
  rsp_e rsp_q[$];

  wb_ooo_arbiter #(
    .NUM_M(2), .AW(32), .DW(64), .TW(8), .MAX_OUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_w(m_dat_w), .m_sel(m_sel), .m_tga(m_tga),
    .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .m_dat_r(m_dat_r), .m_tgd(m_tgd),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_tga(s_tga),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .s_dat_r(s_dat_r), .s_tgd(s_tgd), .unexp_rsp(unexp_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // scoreboard monitor, sampled 4 time units after each rising edge
  always begin
    @(posedge clk);
    #4;
    if (rst_n) begin
      if (s_stb && !s_stall) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL req_extra got tga %h want none", s_tga);
        end else begin
          req_e e;
          logic [8:0] t;
          e = req_q.pop_front();
          t = {e.idx[0], e.tga};
          if (s_tga !== t || s_adr !== e.adr || s_we !== 1'b1 ||
              s_dat_w !== {32'hDA7A0000, e.adr} || s_sel !== 8'hFF) begin
            errors++;
            $display("FAIL req_sb got tga %h adr %h want tga %h adr %h",
                     s_tga, s_adr, t, e.adr);
          end
        end
      end
      if (rsp_q.size() != 0) begin
        rsp_e r;
        r = rsp_q.pop_front();
        checks++;
        if (m_ack !== r.ack || m_err !== r.err || m_rty !== r.rty ||
            (r.chk && (m_tgd !== r.tgd || m_dat_r !== r.dat))) begin
          errors++;
          $display("FAIL rsp_sb got a%b e%b r%b tgd %h want a%b e%b r%b tgd %h",
                   m_ack, m_err, m_rty, m_tgd, r.ack, r.err, r.rty, r.tgd);
        end
      end else if (|{m_ack, m_err, m_rty}) begin
        checks++;
        errors++;
        $display("FAIL rsp_extra got a%b e%b r%b want none", m_ack, m_err, m_rty);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit on,
                       input logic [7:0] tga, input logic [31:0] adr);
    m_cyc[i] = on;
    m_stb[i] = on;
    m_we[i]  = 1'b1;
    m_tga[i*8 +: 8]    = tga;
    m_adr[i*32 +: 32]  = adr;
    m_dat_w[i*64 +: 64] = {32'hDA7A0000, adr};
    m_sel[i*8 +: 8]    = 8'hFF;
  endtask

  task automatic exp_req(input int idx, input logic [7:0] tga,
                         input logic [31:0] adr);
    req_e e;
    e.idx = idx;
    e.tga = tga;
    e.adr = adr;
    req_q.push_back(e);
  endtask

  task automatic send_rsp(input int kind, input logic [8:0] tgd,
                          input logic [1:0] oh);
    rsp_e r;
    logic [63:0] d;
    d = 64'hC0DE_0000_0000_0000 | 64'(tgd);
    s_tgd   = tgd;
    s_dat_r = d;
    s_ack   = kind == 0;
    s_err   = kind == 1;
    s_rty   = kind == 2;
    r.ack = (kind == 0) ? oh : 2'b00;
    r.err = (kind == 1) ? oh : 2'b00;
    r.rty = (kind == 2) ? oh : 2'b00;
    r.tgd = tgd[7:0];
    r.dat = d;
    r.chk = oh != 2'b00;
    rsp_q.push_back(r);
    cyc();
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11; m_we = '0;
    m_adr = '0; m_dat_w = '0; m_sel = '0; m_tga = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    s_dat_r = '0; s_tgd = '0;
    #12;
    checks++;
    if (m_stall !== 2'b11 || s_stb !== 1'b0 || s_cyc !== 1'b0 ||
        m_ack !== 2'b00 || m_tgd !== 8'h00 || unexp_rsp !== 1'b0) begin
      errors++;
      $display("FAIL reset got stall %b stb %b cyc %b ack %b unexp %b want 11 0 0 00 0",
               m_stall, s_stb, s_cyc, m_ack, unexp_rsp);
    end
    m_cyc = 2'b00; m_stb = 2'b00;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    set_m(0, 1, 8'h5A, 32'h100);
    exp_req(0, 8'h5A, 32'h100);
    #1;
    checks++;
    if (m_stall !== 2'b10) begin
      errors++;
      $display("FAIL single_stall got %b want 10", m_stall);
    end
    cyc();
    set_m(0, 0, 8'h5A, 32'h100);
    #1;
    checks++;
    if (s_stb !== 1'b1 || s_tga !== 9'h05A) begin
      errors++;
      $display("FAIL single_stb got stb %b tga %h want 1 05a", s_stb, s_tga);
    end
    cyc();
    send_rsp(0, 9'h05A, 2'b01);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL single_cyc got %b want 0", s_cyc);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] w;
    set_m(0, 1, 8'h10, 32'h110);
    set_m(1, 1, 8'h20, 32'h120);
    for (int k = 0; k < 4; k++) begin
      int g;
      g = (k % 2 == 0) ? 1 : 0;
      exp_req(g, (g == 0) ? 8'h10 : 8'h20, (g == 0) ? 32'h110 : 32'h120);
      w = (g == 0) ? 2'b10 : 2'b01;
      #1;
      checks++;
      if (m_stall !== w) begin
        errors++;
        $display("FAIL rr_stall%0d got %b want %b", k, m_stall, w);
      end
      cyc();
    end
    set_m(0, 0, 8'h10, 32'h110);
    set_m(1, 0, 8'h20, 32'h120);
    cyc();
    send_rsp(0, 9'h120, 2'b10);
    send_rsp(0, 9'h010, 2'b01);
    send_rsp(0, 9'h010, 2'b01);
    send_rsp(0, 9'h120, 2'b10);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain got cyc %b want 0", s_cyc);
    end
  endtask

  task automatic test_out_of_order();
    set_m(0, 1, 8'h01, 32'h201);
    exp_req(0, 8'h01, 32'h201);
    cyc();
    set_m(0, 1, 8'h02, 32'h202);
    exp_req(0, 8'h02, 32'h202);
    cyc();
    set_m(0, 0, 8'h02, 32'h202);
    set_m(1, 1, 8'h03, 32'h203);
    exp_req(1, 8'h03, 32'h203);
    cyc();
    set_m(1, 0, 8'h03, 32'h203);
    cyc();
    cyc();
    #1;
    checks++;
    if (s_stb !== 1'b0 || s_cyc !== 1'b1) begin
      errors++;
      $display("FAIL ooo_busy got stb %b cyc %b want 0 1", s_stb, s_cyc);
    end
    send_rsp(0, 9'h103, 2'b10);
    send_rsp(0, 9'h001, 2'b01);
    send_rsp(0, 9'h002, 2'b01);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL ooo_drain got cyc %b want 0", s_cyc);
    end
  endtask

  task automatic test_limit();
    for (int k = 0; k < 4; k++) begin
      set_m(0, 1, 8'h40 + 8'(k), 32'h300 + 32'(k));
      exp_req(0, 8'h40 + 8'(k), 32'h300 + 32'(k));
      cyc();
    end
    set_m(0, 0, 8'h44, 32'h304);
    cyc();
    set_m(0, 1, 8'h44, 32'h304);
    set_m(1, 1, 8'h50, 32'h350);
    exp_req(1, 8'h50, 32'h350);
    #1;
    checks++;
    if (m_stall !== 2'b01) begin
      errors++;
      $display("FAIL limit_m1 got %b want 01", m_stall);
    end
    cyc();
    set_m(1, 0, 8'h50, 32'h350);
    #1;
    checks++;
    if (m_stall !== 2'b11) begin
      errors++;
      $display("FAIL limit_hold got %b want 11", m_stall);
    end
    send_rsp(0, 9'h040, 2'b01);
    exp_req(0, 8'h44, 32'h304);
    #1;
    checks++;
    if (m_stall !== 2'b10) begin
      errors++;
      $display("FAIL limit_release got %b want 10", m_stall);
    end
    cyc();
    set_m(0, 0, 8'h44, 32'h304);
    cyc();
    send_rsp(0, 9'h041, 2'b01);
    send_rsp(0, 9'h042, 2'b01);
    send_rsp(0, 9'h150, 2'b10);
    send_rsp(0, 9'h043, 2'b01);
    send_rsp(0, 9'h044, 2'b01);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL limit_drain got cyc %b want 0", s_cyc);
    end
  endtask

  task automatic test_stall();
    set_m(0, 1, 8'h60, 32'h400);
    exp_req(0, 8'h60, 32'h400);
    cyc();
    s_stall = 1'b1;
    set_m(0, 1, 8'h61, 32'h401);
    set_m(1, 1, 8'h70, 32'h470);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (m_stall !== 2'b11 || s_stb !== 1'b1 || s_tga !== 9'h060 ||
          s_adr !== 32'h400) begin
        errors++;
        $display("FAIL stall%0d got stall %b tga %h adr %h want 11 060 400",
                 k, m_stall, s_tga, s_adr);
      end
      cyc();
    end
    s_stall = 1'b0;
    exp_req(1, 8'h70, 32'h470);
    #1;
    checks++;
    if (m_stall !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got %b want 01", m_stall);
    end
    cyc();
    set_m(0, 0, 8'h61, 32'h401);
    set_m(1, 0, 8'h70, 32'h470);
    cyc();
    send_rsp(1, 9'h060, 2'b01);
    send_rsp(2, 9'h170, 2'b10);
    #1;
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain got cyc %b want 0", s_cyc);
    end
  endtask

  task automatic test_unexpected();
    send_rsp(0, 9'h177, 2'b00);
    #1;
    checks++;
    if (unexp_rsp !== 1'b1) begin
      errors++;
      $display("FAIL unexp_set got %b want 1", unexp_rsp);
    end
    cyc();
    #1;
    checks++;
    if (unexp_rsp !== 1'b1) begin
      errors++;
      $display("FAIL unexp_sticky got %b want 1", unexp_rsp);
    end
  endtask

  task automatic test_reset_mid();
    set_m(0, 1, 8'h80, 32'h500);
    set_m(1, 1, 8'h90, 32'h590);
    exp_req(0, 8'h80, 32'h500);
    cyc();
    exp_req(1, 8'h90, 32'h590);
    cyc();
    exp_req(0, 8'h80, 32'h500);
    send_rsp(0, 9'h080, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_stb !== 1'b0 || s_cyc !== 1'b0 || m_ack !== 2'b00 ||
        m_tgd !== 8'h00 || m_dat_r !== 64'h0 || unexp_rsp !== 1'b0 ||
        m_stall !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid got stb %b cyc %b ack %b tgd %h unexp %b stall %b want 0 0 00 00 0 11",
               s_stb, s_cyc, m_ack, m_tgd, unexp_rsp, m_stall);
    end
    set_m(0, 0, 8'h80, 32'h500);
    set_m(1, 0, 8'h90, 32'h590);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty got req %0d rsp %0d want 0 0",
               req_q.size(), rsp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_out_of_order();
    test_limit();
    test_stall();
    test_unexpected();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
